// File: rtl/message_send_controller_if.sv
// Bundle of key-source, link-handshake and status signals of the message send controller.
// The controller sits on the slave side; the key source / link / display side is the master.
interface message_send_controller_if #(
   parameter int MSG_CHARS = 16
);
   localparam int CW = $clog2(MSG_CHARS + 1);

   logic                   enable;
   logic                   key_valid;
   logic [7:0]             key_ascii;
   logic                   link_done;
   logic                   data_ready;
   logic [8*MSG_CHARS-1:0] message_out;
   logic [CW-1:0]          char_count;
   logic                   busy;
   logic                   echo_valid;
   logic [7:0]             echo_ascii;
   logic                   send_ok;
   logic                   send_timeout;

   modport master (
      output enable, key_valid, key_ascii, link_done,
      input  data_ready, message_out, char_count, busy,
      input  echo_valid, echo_ascii, send_ok, send_timeout
   );

   modport slave (
      input  enable, key_valid, key_ascii, link_done,
      output data_ready, message_out, char_count, busy,
      output echo_valid, echo_ascii, send_ok, send_timeout
   );
endinterface

// File: rtl/message_send_controller.sv
// Message send controller: builds a MSG_CHARS-character text buffer from decoded
// keystrokes, echoes accepted edits to the LCD and hands the buffer to the GPIO
// link with a data_ready/done handshake guarded by a timeout.
module message_send_controller #(
   parameter int         MSG_CHARS      = 16,
   parameter logic [7:0] ENTER_CODE     = 8'd13,
   parameter logic [7:0] BKSP_CODE      = 8'd8,
   parameter int         TIMEOUT_CYCLES = 250000000
) (
   input  logic                     clock,
   input  logic                     RESETN,
   message_send_controller_if.slave bus
);
   localparam int                     CW     = $clog2(MSG_CHARS + 1);
   localparam int                     TW     = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0]          FULL   = CW'(MSG_CHARS);
   localparam logic [TW-1:0]          T_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [8*MSG_CHARS-1:0] BLANK  = {MSG_CHARS{8'h20}};

   typedef enum logic [1:0] {
      ST_COMPOSE  = 2'd0,
      ST_SEND     = 2'd1,
      ST_WAIT_CLR = 2'd2
   } state_t;

   state_t                 r_state;
   logic                   r_data_ready;
   logic [8*MSG_CHARS-1:0] r_msg;
   logic [CW-1:0]          r_count;
   logic                   r_echo_valid;
   logic [7:0]             r_echo_ascii;
   logic                   r_send_ok;
   logic                   r_send_timeout;
   logic [TW-1:0]          r_tcnt;
   logic                   r_sync1;
   logic                   r_sync2;
   logic                   r_sync_prev;

   logic                   w_done_rise;
   logic                   w_printable;
   logic                   w_key_event;

   assign w_done_rise = r_sync2 & ~r_sync_prev;
   assign w_printable = (bus.key_ascii >= 8'h20) && (bus.key_ascii <= 8'h7E);
   assign w_key_event = bus.enable & bus.key_valid;

   // link_done comes from the slow link clock: two flops to resynchronise, one more for edge detect
   always_ff @(posedge clock or negedge RESETN) begin
      if (!RESETN) begin
         r_sync1     <= 1'b0;
         r_sync2     <= 1'b0;
         r_sync_prev <= 1'b0;
      end else begin
         r_sync1     <= bus.link_done;
         r_sync2     <= r_sync1;
         r_sync_prev <= r_sync2;
      end
   end

   // Compose / send / wait-for-release sequencer with the message buffer and all registered outputs
   always_ff @(posedge clock or negedge RESETN) begin
      if (!RESETN) begin
         r_state        <= ST_COMPOSE;
         r_data_ready   <= 1'b0;
         r_msg          <= BLANK;
         r_count        <= '0;
         r_echo_valid   <= 1'b0;
         r_echo_ascii   <= 8'h00;
         r_send_ok      <= 1'b0;
         r_send_timeout <= 1'b0;
         r_tcnt         <= '0;
      end else begin
         r_echo_valid   <= 1'b0;
         r_send_ok      <= 1'b0;
         r_send_timeout <= 1'b0;
         case (r_state)
            ST_COMPOSE: begin
               r_data_ready <= 1'b0;
               if (w_key_event) begin
                  if (w_printable) begin
                     if (r_count < FULL) begin
                        for (int i = 0; i < MSG_CHARS; i++) begin
                           if (CW'(i) == r_count) begin
                              r_msg[8*i +: 8] <= bus.key_ascii;
                           end
                        end
                        r_count      <= r_count + CW'(1);
                        r_echo_valid <= 1'b1;
                        r_echo_ascii <= bus.key_ascii;
                     end
                  end else if (bus.key_ascii == BKSP_CODE) begin
                     if (r_count != '0) begin
                        for (int i = 0; i < MSG_CHARS; i++) begin
                           if (CW'(i + 1) == r_count) begin
                              r_msg[8*i +: 8] <= 8'h20;
                           end
                        end
                        r_count      <= r_count - CW'(1);
                        r_echo_valid <= 1'b1;
                        r_echo_ascii <= BKSP_CODE;
                     end
                  end else if (bus.key_ascii == ENTER_CODE) begin
                     if (r_count != '0) begin
                        r_state      <= ST_SEND;
                        r_data_ready <= 1'b1;
                        r_tcnt       <= '0;
                     end
                  end
               end
            end
            ST_SEND: begin
               // an acknowledge beats a timeout landing in the same cycle
               if (w_done_rise) begin
                  r_send_ok    <= 1'b1;
                  r_msg        <= BLANK;
                  r_count      <= '0;
                  r_data_ready <= 1'b0;
                  r_state      <= ST_WAIT_CLR;
               end else if (r_tcnt == T_LAST) begin
                  r_send_timeout <= 1'b1;
                  r_data_ready   <= 1'b0;
                  r_state        <= ST_COMPOSE;
               end else begin
                  r_data_ready <= 1'b1;
                  r_tcnt       <= r_tcnt + TW'(1);
               end
            end
            ST_WAIT_CLR: begin
               r_data_ready <= 1'b0;
               if (!r_sync2) begin
                  r_state <= ST_COMPOSE;
               end
            end
            default: begin
               r_state      <= ST_COMPOSE;
               r_data_ready <= 1'b0;
            end
         endcase
      end
   end

   assign bus.data_ready   = r_data_ready;
   assign bus.message_out  = r_msg;
   assign bus.char_count   = r_count;
   assign bus.busy         = (r_state != ST_COMPOSE);
   assign bus.echo_valid   = r_echo_valid;
   assign bus.echo_ascii   = r_echo_ascii;
   assign bus.send_ok      = r_send_ok;
   assign bus.send_timeout = r_send_timeout;
endmodule

// File: tb/tb_message_send_controller.sv
// Testbench for message_send_controller: directed scenarios with literal expectations
// plus a randomized phase, all checked every cycle against a queue-based model.
module tb_message_send_controller;
   localparam int         MSG_CHARS = 16;
   localparam int         T         = 100;
   localparam logic [7:0] ENTER     = 8'd13;
   localparam logic [7:0] BKSP      = 8'd8;
   localparam int         P_COMPOSE = 0;
   localparam int         P_SEND    = 1;
   localparam int         P_WAIT    = 2;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   message_send_controller_if #(.MSG_CHARS(MSG_CHARS)) bus();

   message_send_controller #(
      .MSG_CHARS      (MSG_CHARS),
      .ENTER_CODE     (ENTER),
      .BKSP_CODE      (BKSP),
      .TIMEOUT_CYCLES (T)
   ) dut (
      .clock  (clk),
      .RESETN (rst_n),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [7:0] q[$];
   int         m_phase = P_COMPOSE;
   int         m_age   = 0;
   logic [3:1] hist    = 3'b000;   // link_done as seen at the last three edges
   logic       m_echo_v = 1'b0;
   logic [7:0] m_echo_a = 8'h00;
   logic       m_ok = 1'b0;
   logic       m_to = 1'b0;

   function automatic logic [127:0] exp_msg();
      logic [127:0] m;
      for (int i = 0; i < MSG_CHARS; i++) begin
         m[8*i +: 8] = (i < q.size()) ? q[i] : 8'h20;
      end
      return m;
   endfunction

   task automatic model_step();
      logic rise;
      rise     = hist[2] & ~hist[3];
      m_echo_v = 1'b0;
      m_ok     = 1'b0;
      m_to     = 1'b0;
      if (m_phase == P_COMPOSE) begin
         if (bus.enable && bus.key_valid) begin
            if (bus.key_ascii >= 8'h20 && bus.key_ascii <= 8'h7E) begin
               if (q.size() < MSG_CHARS) begin
                  q.push_back(bus.key_ascii);
                  m_echo_v = 1'b1;
                  m_echo_a = bus.key_ascii;
               end
            end else if (bus.key_ascii == BKSP) begin
               if (q.size() > 0) begin
                  void'(q.pop_back());
                  m_echo_v = 1'b1;
                  m_echo_a = BKSP;
               end
            end else if (bus.key_ascii == ENTER && q.size() > 0) begin
               m_phase = P_SEND;
               m_age   = 0;
            end
         end
      end else if (m_phase == P_SEND) begin
         m_age++;
         if (rise) begin
            m_ok    = 1'b1;
            q.delete();
            m_phase = P_WAIT;
         end else if (m_age == T) begin
            m_to    = 1'b1;
            m_phase = P_COMPOSE;
         end
      end else begin
         if (!hist[2]) m_phase = P_COMPOSE;
      end
      hist = {hist[2:1], bus.link_done};
   endtask

   // Model update on each edge (or async reset), then compare every output just after
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q.delete();
         m_phase  = P_COMPOSE;
         m_age    = 0;
         hist     = 3'b000;
         m_echo_v = 1'b0;
         m_echo_a = 8'h00;
         m_ok     = 1'b0;
         m_to     = 1'b0;
      end else begin
         model_step();
      end
      #1;
      check("message_out",  bus.message_out,  exp_msg());
      check("char_count",   128'(bus.char_count), 128'(q.size()));
      check("data_ready",   128'(bus.data_ready), 128'(m_phase == P_SEND));
      check("busy",         128'(bus.busy),       128'(m_phase != P_COMPOSE));
      check("echo_valid",   128'(bus.echo_valid), 128'(m_echo_v));
      check("echo_ascii",   128'(bus.echo_ascii), 128'(m_echo_a));
      check("send_ok",      128'(bus.send_ok),    128'(m_ok));
      check("send_timeout", 128'(bus.send_timeout), 128'(m_to));
   end

   // ---------------- stimulus helpers ----------------
   task automatic key(input logic [7:0] k, output logic echoed);
      @(negedge clk);
      bus.key_valid = 1'b1;
      bus.key_ascii = k;
      @(negedge clk);
      bus.key_valid = 1'b0;
      echoed = bus.echo_valid;
   endtask

   task automatic ack();
      bus.link_done = 1'b1;
      repeat (5) @(negedge clk);
      bus.link_done = 1'b0;
      repeat (5) @(negedge clk);
   endtask

   logic [127:0] blank;
   logic [127:0] tmp;
   logic         e;
   logic [7:0]   k16;
   int           n;
   int           echoes;
   logic         got;

   initial begin
      blank         = {MSG_CHARS{8'h20}};
      bus.enable    = 1'b0;
      bus.key_valid = 1'b0;
      bus.key_ascii = 8'h00;
      bus.link_done = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_data_ready", 128'(bus.data_ready), 128'(0));
      check("rst_count",      128'(bus.char_count), 128'(0));
      check("rst_msg",        bus.message_out, blank);
      check("rst_busy",       128'(bus.busy), 128'(0));
      rst_n = 1'b1;
      @(negedge clk);

      // 1: "Hi" then Enter
      bus.enable = 1'b1;
      key(8'h48, e);
      key(8'h69, e);
      key(ENTER, e);
      tmp = blank;
      tmp[15:0] = 16'h6948;
      check("t1_msg",   bus.message_out, tmp);
      check("t1_count", 128'(bus.char_count), 128'(2));
      check("t1_dr",    128'(bus.data_ready), 128'(1));

      // 2: link acknowledge
      bus.link_done = 1'b1;
      n = 0; got = 1'b0;
      while (!got && n < 8) begin
         @(negedge clk);
         n++;
         if (bus.send_ok) got = 1'b1;
      end
      check("t2_ok_latency", 128'(n), 128'(3));
      check("t2_count", 128'(bus.char_count), 128'(0));
      check("t2_msg",   bus.message_out, blank);
      check("t2_dr",    128'(bus.data_ready), 128'(0));
      repeat (2) @(negedge clk);
      check("t2_busy_held", 128'(bus.busy), 128'(1));
      bus.link_done = 1'b0;
      @(negedge clk);
      check("t2_busy_n1", 128'(bus.busy), 128'(1));
      @(negedge clk);
      check("t2_busy_n2", 128'(bus.busy), 128'(1));
      @(negedge clk);
      check("t2_busy_n3", 128'(bus.busy), 128'(0));

      // 3: overfill with 17 printable keys
      echoes = 0;
      k16 = 8'h00;
      for (int i = 0; i < 17; i++) begin
         logic [7:0] kk;
         kk = 8'($urandom_range(32, 126));
         if (i == 15) k16 = kk;
         key(kk, e);
         if (e) echoes++;
         if (i == 16) check("t3_17th_echo", 128'(e), 128'(0));
      end
      check("t3_count",  128'(bus.char_count), 128'(16));
      check("t3_echoes", 128'(echoes), 128'(16));
      tmp = bus.message_out;
      check("t3_slot15", 128'(tmp[127:120]), 128'(k16));
      key(ENTER, e);
      ack();

      // 4: backspace
      key(8'h61, e);
      key(8'h62, e);
      key(BKSP, e);
      tmp = bus.message_out;
      check("t4_count", 128'(bus.char_count), 128'(1));
      check("t4_slot1", 128'(tmp[15:8]), 128'(8'h20));
      check("t4_echo",  128'(bus.echo_ascii), 128'(8'h08));
      check("t4_echoed", 128'(e), 128'(1));
      key(BKSP, e);
      check("t4_bk2_echoed", 128'(e), 128'(1));
      check("t4_bk2_count",  128'(bus.char_count), 128'(0));
      key(BKSP, e);
      check("t4_bk3_echoed", 128'(e), 128'(0));

      // 5: timeout, then retry
      key(8'h78, e);
      key(ENTER, e);
      check("t5_dr_up", 128'(bus.data_ready), 128'(1));
      n = 0; got = 1'b0;
      while (!got && n < 250) begin
         @(negedge clk);
         n++;
         if (bus.send_timeout) got = 1'b1;
      end
      check("t5_timeout_latency", 128'(n), 128'(T));
      tmp = bus.message_out;
      check("t5_dr",    128'(bus.data_ready), 128'(0));
      check("t5_slot0", 128'(tmp[7:0]), 128'(8'h78));
      check("t5_count", 128'(bus.char_count), 128'(1));
      key(ENTER, e);
      check("t5_retry_dr", 128'(bus.data_ready), 128'(1));
      ack();

      // 6: disabled keys, empty Enter, reset mid-send
      bus.enable = 1'b0;
      key(8'h7A, e);
      check("t6_dis_echo",  128'(e), 128'(0));
      check("t6_dis_count", 128'(bus.char_count), 128'(0));
      bus.enable = 1'b1;
      key(ENTER, e);
      check("t6_empty_busy", 128'(bus.busy), 128'(0));
      key(8'h71, e);
      key(ENTER, e);
      repeat (10) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("t6_rst_dr",    128'(bus.data_ready), 128'(0));
      check("t6_rst_busy",  128'(bus.busy), 128'(0));
      check("t6_rst_count", 128'(bus.char_count), 128'(0));
      check("t6_rst_msg",   bus.message_out, blank);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // randomized phase
      for (int c = 0; c < 1500; c++) begin
         int r;
         @(negedge clk);
         bus.enable    = ($urandom_range(0, 9) != 0);
         bus.key_valid = ($urandom_range(0, 2) == 0);
         r = $urandom_range(0, 9);
         if (r <= 5)      bus.key_ascii = 8'($urandom_range(32, 126));
         else if (r == 6) bus.key_ascii = BKSP;
         else if (r == 7) bus.key_ascii = ENTER;
         else if (r == 8) bus.key_ascii = 8'($urandom_range(0, 31));
         else             bus.key_ascii = 8'($urandom_range(127, 255));
         if ($urandom_range(0, 29) == 0) bus.link_done = ~bus.link_done;
      end
      bus.key_valid = 1'b0;
      bus.link_done = 1'b0;
      repeat (10) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
